// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader for the instruction memory.
// Optional ld_last checksum byte: define IMEM_LOADER_CHKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              ld_done,
    output logic              ld_err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] FULL    = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [1:0]          lane_q, lane_d;
    logic [31:0]         word_q, word_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                ld_err_q, ld_err_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;

    logic                accept;
    logic                overflow;
    logic [4:0]          lane_sh;
    logic [31:0]         merged;

`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]          sum_q, sum_d;
    logic [7:0]          sum_all;
    logic                chk_bad_q, chk_bad_d;

    assign sum_all  = sum_q + ld_byte;
    // The checksum byte carries no data, so it may arrive with memory full.
    assign overflow = (idx_q == FULL) && !ld_last;
`else
    assign overflow = (idx_q == FULL);
`endif

    assign accept  = (state_q == S_LOAD) && ld_valid;
    assign lane_sh = {lane_q, 3'b000};
    assign merged  = word_q | (32'(ld_byte) << lane_sh);

    // Next-state, byte assembly and write-strobe generation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        ld_err_d    = ld_err_q;
        cnt_d       = cnt_q + {{ADDR_W{1'b0}}, mem_we_q};
`ifdef IMEM_LOADER_CHKSUM_EN
        sum_d       = sum_q;
        chk_bad_d   = chk_bad_q;
`endif
        unique case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (ld_start) begin
                    state_d  = S_LOAD;
                    idx_d    = '0;
                    lane_d   = '0;
                    word_d   = '0;
                    cnt_d    = '0;
                    ld_err_d = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
                    sum_d     = '0;
                    chk_bad_d = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (overflow) begin
                        state_d  = S_ERR;
                        ld_err_d = 1'b1;
                    end
`ifdef IMEM_LOADER_CHKSUM_EN
                    else if (ld_last) begin
                        state_d   = S_FLUSH;
                        chk_bad_d = (sum_all != 8'h00);
                        lane_d    = '0;
                        word_d    = '0;
                        if (lane_q != 2'd0) begin
                            mem_we_d    = 1'b1;
                            mem_waddr_d = idx_q[ADDR_W-1:0];
                            mem_wdata_d = word_q;
                            idx_d       = idx_q + IDX_ONE;
                        end
                    end
`endif
                    else begin
                        lane_d = lane_q + 2'd1;
                        word_d = merged;
`ifdef IMEM_LOADER_CHKSUM_EN
                        sum_d  = sum_all;
`endif
                        if (lane_q == 2'd3 || ld_last) begin
                            mem_we_d    = 1'b1;
                            mem_waddr_d = idx_q[ADDR_W-1:0];
                            mem_wdata_d = merged;
                            idx_d       = idx_q + IDX_ONE;
                            lane_d      = '0;
                            word_d      = '0;
                        end
                        if (ld_last) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
`ifdef IMEM_LOADER_CHKSUM_EN
                if (chk_bad_q) begin
                    state_d  = S_ERR;
                    ld_err_d = 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any load in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            lane_q      <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            ld_err_q    <= 1'b0;
            cnt_q       <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum_q       <= '0;
            chk_bad_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_err_q    <= ld_err_d;
            cnt_q       <= cnt_d;
`ifdef IMEM_LOADER_CHKSUM_EN
            sum_q       <= sum_d;
            chk_bad_q   <= chk_bad_d;
`endif
        end
    end

    assign ld_ready   = (state_q == S_LOAD);
    assign core_hold  = (state_q != S_RUN);
    assign ld_done    = (state_q == S_DONE);
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign ld_err     = ld_err_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed + random image loads against a queue model.
// Define IMEM_LOADER_CHKSUM_EN to also exercise the checksum build.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        mem_we;
    logic [5:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        ld_done;
    logic        ld_err;
    logic [6:0]  word_count;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    int we_base  = 0;
    int load_id  = 0;

    logic [31:0] mem_tb  [0:63];
    int          mem_gen [0:63];

`ifdef IMEM_LOADER_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .ld_done    (ld_done),
        .ld_err     (ld_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Behaves as the instruction memory: latch every write strobe.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            mem_tb[mem_waddr]  = mem_wdata;
            mem_gen[mem_waddr] = load_id;
            we_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Little-endian word w of a byte image, zero-padded past the end.
    function automatic logic [31:0] model_word(input logic [7:0] img[$],
                                               input int w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++)
            if (4 * w + b < img.size()) r[8*b +: 8] = img[4*w+b];
        return r;
    endfunction

    task automatic new_load();
        load_id++;
        we_base = we_cnt;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic last,
                              input logic exp_we, input string tag);
        chk({tag, "_ready"}, ld_ready, 1'b1);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        cycle();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_byte  = 8'($urandom);
        chk({tag, "_we"}, mem_we, exp_we);
    endtask

    task automatic run_load(input logic [7:0] img[$], input int gmin,
                            input int gmax, input logic bad);
        int         n;
        int         nw;
        logic [7:0] s;
        logic       lastb;
        n  = img.size();
        nw = (n + 3) / 4;
        s  = 8'h00;
        new_load();
        start_pulse();
        chk("hold_in_load", core_hold, 1'b1);
        for (int j = 0; j < n; j++) begin
            repeat ($urandom_range(gmax, gmin)) cycle();
            s     = s + img[j];
            lastb = !CHK && (j == n - 1);
            drive_byte(img[j], lastb, ((j + 1) % 4 == 0) || lastb, "img");
        end
`ifdef IMEM_LOADER_CHKSUM_EN
        repeat ($urandom_range(gmax, gmin)) cycle();
        drive_byte(bad ? 8'(8'h00 - s - 8'h01) : 8'(8'h00 - s), 1'b1,
                   (n % 4) != 0, "cks");
`endif
        cycle();
        chk("done_pulse", ld_done, !bad);
        chk("hold_at_done", core_hold, 1'b1);
        cycle();
        chk("hold_release", core_hold, bad);
        chk("err_flag", ld_err, bad);
        chk("done_clear", ld_done, 1'b0);
        chk("word_count", word_count, nw);
        chk("we_count", we_cnt - we_base, nw);
        for (int w = 0; w < nw; w++)
            chk("mem_word", mem_tb[w], model_word(img, w));
        if (nw < 64) chk("mem_untouched", mem_gen[nw] == load_id, 1'b0);
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_ready"}, ld_ready, 1'b0);
        chk({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_waddr"}, mem_waddr, 6'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_hold"}, core_hold, 1'b1);
        chk({tag, "_done"}, ld_done, 1'b0);
        chk({tag, "_err"}, ld_err, 1'b0);
        chk({tag, "_wcount"}, word_count, 7'd0);
    endtask

    initial begin
        logic [7:0] img[$];
        logic [7:0] spec8[$];
        logic [7:0] b;
        for (int i = 0; i < 64; i++) begin
            mem_tb[i]  = 32'h0;
            mem_gen[i] = 0;
        end
        rst      = 1'b1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_byte  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset_values("rst");
        rst = 1'b0;
        cycle();
        chk("idle_hold", core_hold, 1'b1);
        chk("idle_ready", ld_ready, 1'b0);

        spec8 = '{8'h33, 8'h06, 8'h99, 8'h01, 8'h33, 8'h04, 8'h34, 8'h40};
        run_load(spec8, 0, 0, 1'b0);
        chk("spec_w0", mem_tb[0], 32'h01990633);
        chk("spec_w1", mem_tb[1], 32'h40340433);

        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        run_load(img, 0, 0, 1'b0);
        chk("partial_w1", mem_tb[1], 32'h000000AA);

        run_load(spec8, 1, 1, 1'b0);
        chk("bp_w0", mem_tb[0], 32'h01990633);
        chk("bp_w1", mem_tb[1], 32'h40340433);

        for (int it = 0; it < 6; it++) begin
            img.delete();
            repeat ($urandom_range(40, 1)) img.push_back(8'($urandom));
            run_load(img, 0, 2, 1'b0);
        end

        new_load();
        start_pulse();
        img.delete();
        for (int j = 0; j < 257; j++) begin
            b = 8'($urandom);
            img.push_back(b);
            drive_byte(b, 1'b0, (j < 256) && ((j + 1) % 4 == 0), "ovf");
        end
        cycle();
        chk("ovf_err", ld_err, 1'b1);
        chk("ovf_ready", ld_ready, 1'b0);
        chk("ovf_hold", core_hold, 1'b1);
        chk("ovf_done", ld_done, 1'b0);
        chk("ovf_we", mem_we, 1'b0);
        chk("ovf_writes", we_cnt - we_base, 64);
        chk("ovf_wcount", word_count, 7'd64);
        for (int w = 0; w < 64; w++)
            chk("ovf_mem", mem_tb[w], model_word(img, w));
        start_pulse();
        chk("restart_err", ld_err, 1'b0);
        chk("restart_wcount", word_count, 7'd0);
        chk("restart_ready", ld_ready, 1'b1);
        img = '{8'h5A, 8'hC3, 8'h7E};
        run_load(img, 0, 1, 1'b0);

        new_load();
        start_pulse();
        img.delete();
        for (int j = 0; j < 6; j++) begin
            b = 8'($urandom);
            img.push_back(b);
            drive_byte(b, 1'b0, j == 3, "mid");
        end
        #2 rst = 1'b1;
        #1;
        reset_values("midrst");
        chk("midrst_w0", mem_tb[0], model_word(img, 0));
        chk("midrst_w1_kept", mem_gen[1] == load_id, 1'b0);
        chk("midrst_writes", we_cnt - we_base, 1);
        #2 rst = 1'b0;
        cycle();
        chk("post_rst_hold", core_hold, 1'b1);
        chk("post_rst_ready", ld_ready, 1'b0);

`ifdef IMEM_LOADER_CHKSUM_EN
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(img, 0, 0, 1'b0);
        chk("cks_w0", mem_tb[0], 32'h04030201);
        run_load(img, 0, 0, 1'b1);
        start_pulse();
        chk("cks_clear", ld_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot/reprogram controller for the single-cycle core's instruction memory. Accepts a byte stream over a valid/ready port, assembles little-endian 32-bit words, and drives the instruction memory's write port one word per write pulse. Holds the core in reset while loading and releases it when the image is complete, so the datapath never fetches a half-written program.

## Interface
- `DEPTH`, 64, instruction memory capacity in 32-bit words.
- `ADDR_W`, 6, word-index width; must satisfy 2^ADDR_W ≥ DEPTH.
---
- `clk` in 1: single clock domain; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `ld_start` in 1: begin a new image load; sampled in IDLE, RUN and ERR.
- `ld_valid` in 1: the byte on `ld_byte` is valid.
- `ld_byte` in 8: image byte; stream order is word 0 byte 0 (LSB) first.
- `ld_last` in 1: qualifies the final byte of the image.
- `ld_ready` out 1: the loader accepts a byte this cycle.
- `mem_we` out 1: one-cycle write strobe to the instruction memory.
- `mem_waddr` out ADDR_W: word index; byte address = 4 × index.
- `mem_wdata` out 32: assembled word.
- `core_hold` out 1: active-high reset request to the core.
- `ld_done` out 1: one-cycle pulse when the load completes.
- `ld_err` out 1: sticky overflow or checksum error.
- `word_count` out ADDR_W+1: number of words written by the last load.

## Operation
- States: IDLE, LOAD, FLUSH, DONE, RUN, ERR.
- IDLE: `core_hold`=1. Asserting `ld_start` moves to LOAD and clears the word index, byte lane, `word_count` and `ld_err`.
- LOAD: `ld_ready`=1. A byte is accepted when `ld_valid & ld_ready`. The byte goes to lane k, bits [8k+7:8k], and k increments.
  - When the fourth byte is accepted, or `ld_last` is accepted in any lane, the loader registers `mem_wdata`/`mem_waddr` and pulses `mem_we` the next cycle. Then the index increments, `word_count` increments, and the lane resets to 0.
  - Unfilled lanes of a partial final word are written as 0.
  - Accepting `ld_last` moves to FLUSH.
- Overflow: a byte accepted while index = DEPTH (DEPTH words already written) is dropped. `ld_err` sets and the FSM moves to ERR. No write occurs.
- FLUSH: lasts one cycle, with the final `mem_we` pulse. Then moves to DONE.
- DONE: lasts one cycle. `ld_done`=1 and `core_hold` drops to 0 at the end of this cycle. Then moves to RUN.
- RUN: `core_hold`=0 and `ld_ready`=0. `ld_start` moves to LOAD and reasserts `core_hold` in the same cycle the state changes.
- ERR: `core_hold`=1 and `ld_ready`=0. Only `ld_start` leaves ERR, going to LOAD.
- `ld_start` is ignored during LOAD, FLUSH and DONE.
- Reset values: state IDLE, `ld_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `core_hold`=1, `ld_done`=0, `ld_err`=0, `word_count`=0.
- Reset mid-load aborts the load immediately. The core stays held, and memory keeps any words already written.

## Timing
- The loader accepts one byte per cycle, with no bubbles between words.
- Latency from accepting the 4th byte of a word to `mem_we` high is 1 cycle.
- After `ld_last` is accepted:
  - cycle +1: final `mem_we`.
  - cycle +2: `ld_done`=1.
  - cycle +3: `core_hold`=0.
- `mem_we` never stays high for more than 1 cycle per word. Address and data are stable while `mem_we`=1.
- `ld_ready` depends only on state (registered) and never on `ld_valid`.

## Configuration
- `IMEM_LOADER_CHKSUM_EN` defined:
  - The byte accepted with `ld_last` is a checksum, not image data; it is not written.
  - The 8-bit sum of all preceding image bytes, mod 256, plus the checksum byte must equal 0x00.
  - On mismatch, `ld_err` sets, `ld_done` does not pulse, and the FSM goes to ERR instead of DONE. The words already written remain in memory.
  - Any pending partial word is still flushed before this check completes.
- `IMEM_LOADER_CHKSUM_EN` not defined: the `ld_last` byte is ordinary image data and no check is made.

## Test plan
- Reset, then start and stream 8 bytes 0x33,0x06,0x99,0x01,0x33,0x04,0x34,0x40 with `ld_last` on the 8th byte:
  - writes idx0=0x01990633 and idx1=0x40340433.
  - `word_count`=2, `ld_done` pulses at +2, `core_hold`=0 at +3.
- Partial word: 5 bytes ending with 0xAA plus `ld_last`:
  - idx1=0x000000AA.
  - `word_count`=2.
- Backpressure: `ld_valid` toggled every other cycle → identical memory contents; `mem_we` pulses only after complete words.
- Overflow with DEPTH=64:
  - 257 bytes → 64 writes.
  - `ld_err`=1, state ERR, `core_hold`=1.
  - A following `ld_start` clears `ld_err`.
- Reset asserted mid-stream after 6 bytes:
  - all outputs at reset values within the same cycle.
  - idx0 written, idx1 untouched.
- With `IMEM_LOADER_CHKSUM_EN`:
  - Bytes 0x01,0x02,0x03,0x04 then checksum 0xF6 → `ld_done`.
  - Checksum 0xF5 → `ld_err`=1, no `ld_done`.
